// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial engine: FSM encoding, accumulator preset
// and product-width helper.
package factorial_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MUL  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Accumulator preset; zero-extended to OUT_W at the point of use.
  localparam logic [0:0] ONE = 1'b1;

  function automatic int prod_width(input int out_w, input int in_w);
    return out_w + in_w;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter with a registered value and a "q <= 1" compare flag.
// Load has priority over decrement.
module load_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         dec,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         le1
);

  // Counter register: load, decrement or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (ld) begin
      q <= d;
    end else if (dec) begin
      q <= q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      q <= q;
    end
  end

  assign le1 = (q <= {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/factorial_unit.sv
// Self-sequenced factorial engine: iterated multiply of an accumulator by a
// down-counting operand, with sticky overflow detection and optional saturation.
module factorial_unit
  import factorial_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 32,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [IN_W-1:0]  n,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [OUT_W-1:0] result
);

  localparam int PW = prod_width(OUT_W, IN_W);

  state_t            state_r;
  state_t            state_nx_s;
  logic [OUT_W-1:0]  acc_r;
  logic              sticky_r;
  logic [IN_W-1:0]   cnt_q_s;
  logic              cnt_le1_s;
  logic              accept_s;
  logic              step_s;
  logic              finish_s;
  logic [PW-1:0]     prod_s;

  assign accept_s = (state_r == S_IDLE) && go;
  assign step_s   = (state_r == S_MUL) && !cnt_le1_s;
  assign finish_s = (state_r == S_MUL) && cnt_le1_s;
  assign prod_s   = PW'(acc_r) * PW'(cnt_q_s);

  load_down_counter #(
    .W (IN_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .ld  (accept_s),
    .dec (step_s),
    .d   (n),
    .q   (cnt_q_s),
    .le1 (cnt_le1_s)
  );

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (go) begin
          state_nx_s = S_MUL;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_le1_s) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_MUL;
        end
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s == S_MUL);
      done    <= (state_nx_s == S_DONE);
    end
  end

  // Accumulator and sticky overflow; overflow is any bit above OUT_W in a product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= {OUT_W{1'b0}};
      sticky_r <= 1'b0;
    end else if (accept_s) begin
      acc_r    <= OUT_W'(ONE);
      sticky_r <= 1'b0;
    end else if (step_s) begin
      acc_r    <= prod_s[OUT_W-1:0];
      sticky_r <= sticky_r | (|prod_s[PW-1:OUT_W]);
    end else begin
      acc_r    <= acc_r;
      sticky_r <= sticky_r;
    end
  end

  // Result/ovf only change when the computation finishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= {OUT_W{1'b0}};
      ovf    <= 1'b0;
    end else if (finish_s) begin
      result <= (SAT && sticky_r) ? {OUT_W{1'b1}} : acc_r;
      ovf    <= sticky_r;
    end else begin
      result <= result;
      ovf    <= ovf;
    end
  end

endmodule

// File: tb/tb_factorial_unit.sv
// Self-checking bench for factorial_unit: table vectors, random operands against
// a plain-arithmetic factorial model, and hand-written busy/go/reset sequences.
module tb_factorial_unit;

  logic        clk;
  logic        rst;
  logic        go;
  logic [3:0]  n;
  logic        busy, done, ovf;
  logic [31:0] result;
  logic        busy_s, done_s, ovf_s;
  logic [31:0] result_s;

  int errors = 0;
  int checks = 0;

  factorial_unit #(.IN_W(4), .OUT_W(32), .SAT(1'b0)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .busy(busy), .done(done), .ovf(ovf), .result(result)
  );

  factorial_unit #(.IN_W(4), .OUT_W(32), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .busy(busy_s), .done(done_s), .ovf(ovf_s), .result(result_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  n;
    logic [31:0] res;
    logic        ovf;
    logic [31:0] res_sat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: exact factorial in 64 bits (15! fits), then truncate or saturate.
  function automatic logic [63:0] fact64(input int v);
    logic [63:0] p = 64'd1;
    for (int i = 2; i <= v; i++) p = p * 64'(i);
    return p;
  endfunction

  task automatic run_one(input logic [3:0] v, input logic [31:0] e_res,
                         input logic e_ovf, input logic [31:0] e_sat);
    int m, cyc, bcnt;
    m = (v < 4'd2) ? 1 : int'(v);
    @(negedge clk);
    go = 1'b1;
    n  = v;
    @(negedge clk);
    go = 1'b0;
    n  = 4'($urandom);
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 64) begin
      if (busy) bcnt++;
      n = 4'($urandom);
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("done_seen n=%0d", v), 64'(done), 64'd1);
    chk($sformatf("latency n=%0d", v), 64'(cyc), 64'(m));
    chk($sformatf("busy_cycles n=%0d", v), 64'(bcnt), 64'(m));
    chk($sformatf("busy_in_done n=%0d", v), 64'(busy), 64'd0);
    chk($sformatf("result n=%0d", v), 64'(result), 64'(e_res));
    chk($sformatf("ovf n=%0d", v), 64'(ovf), 64'(e_ovf));
    chk($sformatf("sat_result n=%0d", v), 64'(result_s), 64'(e_sat));
    chk($sformatf("sat_ovf n=%0d", v), 64'(ovf_s), 64'(e_ovf));
    @(negedge clk);
    chk($sformatf("done_pulse_len n=%0d", v), 64'(done), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [63:0] f;
    logic [3:0]  rv;
    int last, pulses, cyc;
    logic seen;

    vecs[0] = '{4'd5,  32'd120,        1'b0, 32'd120};
    vecs[1] = '{4'd0,  32'd1,          1'b0, 32'd1};
    vecs[2] = '{4'd1,  32'd1,          1'b0, 32'd1};
    vecs[3] = '{4'd12, 32'd479001600,  1'b0, 32'd479001600};
    vecs[4] = '{4'd13, 32'd1932053504, 1'b1, 32'hFFFFFFFF};
    vecs[5] = '{4'd15, 32'd2004310016, 1'b1, 32'hFFFFFFFF};

    go = 1'b0;
    n  = 4'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_one(vecs[i].n, vecs[i].res, vecs[i].ovf, vecs[i].res_sat);
      if (i == 0) begin
        repeat (10) @(negedge clk);
        chk("result_held", 64'(result), 64'd120);
        chk("ovf_held", 64'(ovf), 64'd0);
      end
    end

    for (int i = 0; i < 10; i++) begin
      rv = 4'($urandom_range(0, 15));
      f  = fact64(int'(rv));
      run_one(rv, f[31:0], (f > 64'hFFFFFFFF), (f > 64'hFFFFFFFF) ? 32'hFFFFFFFF : f[31:0]);
    end

    // go held high: accepts only from IDLE, done every n+2 = 5 cycles
    @(negedge clk);
    go = 1'b1;
    n  = 4'd3;
    last = -1;
    pulses = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (done) begin
        chk("held_go_result", 64'(result), 64'd6);
        if (last >= 0) chk("held_go_spacing", 64'(c - last), 64'd5);
        last = c;
        pulses++;
      end
      n = busy ? 4'($urandom) : 4'd3;
    end
    chk("held_go_pulses", 64'(pulses >= 5), 64'd1);
    go = 1'b0;
    repeat (8) @(negedge clk);

    // Asynchronous reset in the 4th busy cycle of n=10 aborts with no done
    go = 1'b1;
    n  = 4'd10;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    cyc = 0;
    while (cyc < 12) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
      cyc++;
    end
    chk("no_done_after_abort", 64'(seen), 64'd0);
    run_one(4'd4, 32'd24, 1'b0, 32'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
